// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM states, 3x3 tap geometry and filter codes for the
// convolution frame sequencer.
package conv_pkg;
    localparam int TAPS = 9;
    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, DONE} state_t;
    typedef struct packed {
        logic       valid;
        logic       clr;
        logic [3:0] tap;
        logic       zero;
    } tap_t;
    // dx = k%3-1, dy = k/3-1 for tap k
    localparam logic signed [1:0] TAP_DX [TAPS] = '{2'sb11, 2'sb00, 2'sb01,
                                                    2'sb11, 2'sb00, 2'sb01,
                                                    2'sb11, 2'sb00, 2'sb01};
    localparam logic signed [1:0] TAP_DY [TAPS] = '{2'sb11, 2'sb11, 2'sb11,
                                                    2'sb00, 2'sb00, 2'sb00,
                                                    2'sb01, 2'sb01, 2'sb01};
    localparam logic [2:0] FILT_IDENT   = 3'b000;
    localparam logic [2:0] FILT_BLUR    = 3'b001;
    localparam logic [2:0] FILT_SHARPEN = 3'b010;
    localparam logic [2:0] FILT_EDGE    = 3'b011;
    localparam logic [2:0] FILT_EMBOSS  = 3'b100;
endpackage

// File: rtl/conv_tap_delay.sv
// conv_tap_delay: DEPTH-stage shift register aligning the tap stream with
// source memory read data.
module conv_tap_delay
    import conv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  tap_t d,
    output tap_t q
);
    tap_t sr [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign q = sr[DEPTH-1];
endmodule

// File: rtl/conv_frame_sched.sv
// conv_frame_sched: raster-order 3x3 tap sequencer with accumulator control and
// handshaked result writes. CONV_ZERO_PAD_EN selects zero padding over edge clamping.
module conv_frame_sched
    import conv_pkg::*;
#(
    parameter int IMG_W   = 64,
    parameter int IMG_H   = 48,
    parameter int ADDR_W  = 12,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic [2:0]        filter,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              acc_en,
    output logic              acc_clr,
    output logic [3:0]        acc_tap,
    output logic              tap_zero,
    output logic [2:0]        filter_sel,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_ready,
    output logic              busy,
    output logic              complete
);
    localparam int AW = ADDR_W + 2;
    localparam logic signed [AW-1:0] W_S = AW'(IMG_W);
    localparam logic signed [AW-1:0] H_S = AW'(IMG_H);

    state_t state, state_nx;
    logic [3:0] k;
    logic [7:0] cnt;
    logic [ADDR_W-1:0] x, y;
    logic signed [AW-1:0] tx, ty, cx, cy, lin;
    logic oob, fetch, accept, last_k, last_d, last_px, last_col, fire;
    tap_t tap_in, tap_out;

    assign fetch    = state == FETCH;
    assign accept   = ld && (state == IDLE || state == DONE);
    assign last_k   = k == 4'(TAPS - 1);
    assign last_d   = cnt == 8'(MEM_LAT - 1);
    assign last_col = x == ADDR_W'(IMG_W - 1);
    assign last_px  = last_col && y == ADDR_W'(IMG_H - 1);
    assign fire     = state == WRITE && wr_ready;

    // signed tap coordinates so off-image taps are seen before truncation
    assign tx = $signed({2'b00, x}) + AW'(TAP_DX[k]);
    assign ty = $signed({2'b00, y}) + AW'(TAP_DY[k]);
`ifdef CONV_ZERO_PAD_EN
    assign cx  = tx;
    assign cy  = ty;
    assign oob = tx[AW-1] || tx >= W_S || ty[AW-1] || ty >= H_S;
`else
    assign cx  = tx[AW-1] ? '0 : tx >= W_S ? W_S - 1 : tx;
    assign cy  = ty[AW-1] ? '0 : ty >= H_S ? H_S - 1 : ty;
    assign oob = 1'b0;
`endif
    assign lin     = cy * W_S + cx;
    assign rd_en   = fetch && !oob;
    assign rd_addr = rd_en ? lin[ADDR_W-1:0] : '0;

    assign wr_en   = state == WRITE;
    assign wr_addr = wr_en ? ADDR_W'(int'(y) * IMG_W + int'(x)) : '0;
    assign busy    = state == FETCH || state == DRAIN || state == WRITE;

    assign tap_in = '{valid: fetch, clr: fetch && k == 4'd0, tap: k, zero: fetch && oob};

    conv_tap_delay #(.DEPTH(MEM_LAT)) u_delay (
        .clk (clk),
        .rst (rst),
        .d   (tap_in),
        .q   (tap_out)
    );

    assign acc_en   = tap_out.valid;
    assign acc_clr  = tap_out.clr;
    assign acc_tap  = tap_out.tap;
    assign tap_zero = tap_out.zero;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = ld ? FETCH : state;
            FETCH:      state_nx = last_k ? DRAIN : FETCH;
            DRAIN:      state_nx = last_d ? WRITE : DRAIN;
            WRITE:      state_nx = !wr_ready ? WRITE : last_px ? DONE : FETCH;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            k          <= '0;
            cnt        <= '0;
            x          <= '0;
            y          <= '0;
            filter_sel <= '0;
            complete   <= 1'b0;
        end else begin
            state <= state_nx;
            k     <= fetch && !last_k ? k + 4'd1 : 4'd0;
            cnt   <= state == DRAIN && !last_d ? cnt + 8'd1 : 8'd0;
            if (accept) begin
                filter_sel <= filter;
                x          <= '0;
                y          <= '0;
                complete   <= 1'b0;
            end else if (fire) begin
                x        <= last_col ? '0 : x + 1'b1;
                y        <= last_col ? y + 1'b1 : y;
                complete <= last_px;
            end
        end
    end
endmodule

// File: tb/tb_conv_frame_sched.sv
// tb_conv_frame_sched: directed checks of tap sequencing, write handshake,
// frame timing, ld filtering and mid-frame reset on a 4x3 image.
module tb_conv_frame_sched;
    import conv_pkg::*;
    localparam int W = 4, H = 3, AWD = 12, LAT = 2;

    logic clk = 0, rst = 0, ld = 0, wr_ready = 0;
    logic [2:0] filter = '0;
    logic rd_en, acc_en, acc_clr, tap_zero, wr_en, busy, complete;
    logic [AWD-1:0] rd_addr, wr_addr;
    logic [3:0] acc_tap;
    logic [2:0] filter_sel;
    int checks = 0, failures = 0, cyc = 0;

    always #5 clk = ~clk;

    conv_frame_sched #(.IMG_W(W), .IMG_H(H), .ADDR_W(AWD), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .ld(ld), .filter(filter),
        .rd_en(rd_en), .rd_addr(rd_addr), .acc_en(acc_en), .acc_clr(acc_clr),
        .acc_tap(acc_tap), .tap_zero(tap_zero), .filter_sel(filter_sel),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_ready(wr_ready),
        .busy(busy), .complete(complete)
    );

    task automatic step;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic accept(input logic [2:0] f);
        filter = f;
        ld = 1;
        cyc = 0;
        step;
        ld = 0;
        filter = 3'b111;
    endtask

    task automatic test_reset;
        logic [37:0] o;
        rst = 0;
        ld = 0;
        wr_ready = 0;
        step;
        step;
        o = {rd_en, rd_addr, acc_en, acc_clr, acc_tap, tap_zero, filter_sel, wr_en, wr_addr, busy, complete};
        checks++;
        if (o !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", o);
        end
        rst = 1;
        repeat (3) step;
        checks++;
        if (busy !== 0 || complete !== 0 || rd_en !== 0 || wr_en !== 0 || acc_en !== 0) begin
            failures++;
            $display("FAIL idle_after_release busy=%b complete=%b rd_en=%b wr_en=%b exp all 0",
                     busy, complete, rd_en, wr_en);
        end
    endtask

    task automatic test_first_pixel;
        logic [8:0] exp_rd;
        int exp_addr[9];
`ifdef CONV_ZERO_PAD_EN
        exp_rd = 9'b110110000;
        exp_addr = '{0, 0, 0, 0, 0, 1, 0, 4, 5};
`else
        exp_rd = 9'h1ff;
        exp_addr = '{0, 0, 1, 0, 0, 1, 4, 4, 5};
`endif
        wr_ready = 1;
        accept(FILT_BLUR);
        checks++;
        if (filter_sel !== FILT_BLUR || busy !== 1'b1) begin
            failures++;
            $display("FAIL accept filter_sel=%b busy=%b exp 001/1", filter_sel, busy);
        end
        for (int i = 0; i < 11; i++) begin
            if (i < 9) begin
                checks++;
                if (rd_en !== exp_rd[i] || rd_addr !== AWD'(exp_addr[i])) begin
                    failures++;
                    $display("FAIL tap_read k=%0d rd_en=%b rd_addr=%0d exp %b/%0d",
                             i, rd_en, rd_addr, exp_rd[i], exp_addr[i]);
                end
            end
            checks++;
            if (i >= 2) begin
                if (acc_en !== 1'b1 || acc_clr !== (i == 2) || acc_tap !== 4'(i - 2) || tap_zero !== !exp_rd[i-2]) begin
                    failures++;
                    $display("FAIL acc_stream k=%0d en=%b clr=%b tap=%0d zero=%b exp 1/%b/%0d/%b",
                             i - 2, acc_en, acc_clr, acc_tap, tap_zero, i == 2, i - 2, !exp_rd[i-2]);
                end
            end else if (acc_en !== 1'b0) begin
                failures++;
                $display("FAIL acc_early cyc=%0d acc_en=%b exp 0", cyc, acc_en);
            end
            step;
        end
    endtask

    task automatic run_frame(input int stall_px, input int ld_px, input logic [2:0] expf);
        int guard;
        int extra;
        extra = stall_px >= 0 ? 5 : 0;
        for (int p = 0; p < W * H; p++) begin
            guard = 0;
            while (wr_en !== 1'b1 && guard < 40) begin
                step;
                guard++;
            end
            checks++;
            if (wr_en !== 1'b1 || cyc !== 12 * (p + 1) + ((stall_px >= 0 && p > stall_px) ? 5 : 0) ||
                wr_addr !== AWD'(p) || filter_sel !== expf) begin
                failures++;
                $display("FAIL write px=%0d wr_en=%b cyc=%0d wr_addr=%0d filter_sel=%b exp 1/%0d/%0d/%b",
                         p, wr_en, cyc, wr_addr, filter_sel,
                         12 * (p + 1) + ((stall_px >= 0 && p > stall_px) ? 5 : 0), p, expf);
            end
            if (p == stall_px) begin
                wr_ready = 0;
                for (int s = 0; s < 5; s++) begin
                    step;
                    checks++;
                    if (wr_en !== 1'b1 || wr_addr !== AWD'(p)) begin
                        failures++;
                        $display("FAIL stall_hold s=%0d wr_en=%b wr_addr=%0d exp 1/%0d", s, wr_en, wr_addr, p);
                    end
                end
                wr_ready = 1;
            end
            if (p == ld_px) begin
                ld = 1;
                filter = FILT_SHARPEN;
            end
            step;
            ld = 0;
        end
        checks++;
        if (complete !== 1'b1 || busy !== 1'b0 || cyc !== 145 + extra) begin
            failures++;
            $display("FAIL frame_done complete=%b busy=%b cyc=%0d exp 1/0/%0d", complete, busy, cyc, 145 + extra);
        end
    endtask

    task automatic test_frame;
        run_frame(-1, 3, FILT_BLUR);
    endtask

    task automatic test_restart_stall;
        repeat (3) step;
        checks++;
        if (complete !== 1'b1 || busy !== 1'b0 || wr_en !== 1'b0) begin
            failures++;
            $display("FAIL done_hold complete=%b busy=%b wr_en=%b exp 1/0/0", complete, busy, wr_en);
        end
        accept(FILT_EMBOSS);
        checks++;
        if (complete !== 1'b0 || busy !== 1'b1 || filter_sel !== FILT_EMBOSS || rd_addr !== '0) begin
            failures++;
            $display("FAIL restart complete=%b busy=%b filter_sel=%b rd_addr=%0d exp 0/1/100/0",
                     complete, busy, filter_sel, rd_addr);
        end
        run_frame(5, -1, FILT_EMBOSS);
    endtask

    task automatic test_reset_mid;
        logic [37:0] o;
        int seen;
        accept(FILT_BLUR);
        repeat (27) step;
        #2 rst = 0;
        #1;
        o = {rd_en, rd_addr, acc_en, acc_clr, acc_tap, tap_zero, filter_sel, wr_en, wr_addr, busy, complete};
        checks++;
        if (o !== '0) begin
            failures++;
            $display("FAIL async_reset got=%h exp=0", o);
        end
        step;
        rst = 1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step;
            if (wr_en !== 1'b0 || acc_en !== 1'b0 || busy !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0 || complete !== 1'b0) begin
            failures++;
            $display("FAIL after_reset active_cycles=%0d complete=%b exp 0/0", seen, complete);
        end
    endtask

    initial begin
        test_reset;
        test_first_pixel;
        test_frame;
        test_restart_stall;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conv_frame_sched.md
# conv_frame_sched

Frame-level sequencer for the 3x3 convolution datapath. On a load request it latches the filter selection, walks every output pixel of the source image in raster order, issues the nine tap reads per pixel to the source pixel memory, and drives accumulator control aligned to the returned data. It writes each result to the output frame buffer through a ready/enable handshake and flags frame completion to the top level that feeds the VGA path.

## Interface
Parameters:
- IMG_W, 64, image width in pixels
- IMG_H, 48, image height in pixels
- ADDR_W, 12, pixel address width; must satisfy IMG_W*IMG_H <= 2**ADDR_W
- MEM_LAT, 2, source memory read latency in cycles (>=1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- ld  in  1  frame start request
- filter  in  3  filter code, latched when ld is accepted
- rd_en  out  1  source memory read strobe
- rd_addr  out  ADDR_W  source read address
- acc_en  out  1  accumulator add enable, aligned with read data
- acc_clr  out  1  accumulator load (tap 0), aligned with read data
- acc_tap  out  4  tap index 0..8, aligned with read data
- tap_zero  out  1  padded tap: datapath substitutes zero
- filter_sel  out  3  latched filter code, stable for the whole frame
- wr_en  out  1  result write request
- wr_addr  out  ADDR_W  result address, y*IMG_W+x
- wr_ready  in  1  frame buffer accepts the write
- busy  out  1  frame in progress
- complete  out  1  frame done, level

## Operation
- States: IDLE, FETCH, DRAIN, WRITE, DONE.
- IDLE/DONE: ld=1 accepted -> filter_sel<=filter, x=y=0, tap=0, complete<=0, go FETCH. ld in any other state ignored.
- FETCH: one tap per cycle, k=0..8, dx=k%3-1, dy=k/3-1; rd_addr=(y+dy)*IMG_W+(x+dx); after k=8 go DRAIN.
- Out-of-range tap (per Configuration): rd_en=0, rd_addr=0, tap_zero=1 travels with the tap.
- DRAIN: MEM_LAT cycles, no reads; then WRITE.
- WRITE: wr_en=1, wr_addr held until wr_ready=1 sampled; then x++ (wrap to 0, y++); if pixel was (IMG_W-1, IMG_H-1) go DONE, else FETCH.
- DONE: complete=1, busy=0, held until next accepted ld.
- busy=1 in FETCH, DRAIN, WRITE.
- acc_en/acc_clr/acc_tap/tap_zero are the FETCH tap stream delayed by MEM_LAT cycles; acc_clr=1 only for tap 0.
- Address arithmetic in ADDR_W+2 signed bits; range checks done before truncation.

## Timing
- Reset values: all outputs 0, state IDLE, x=y=0.
- ld sampled at edge N -> FETCH tap 0 visible in cycle N+1.
- Per pixel, wr_ready held high: 9 + MEM_LAT + 1 cycles; frame = IMG_W*IMG_H*(10+MEM_LAT).
- Each cycle of wr_ready=0 in WRITE adds one cycle; nothing else advances.
- complete rises the cycle after the last write handshake.
- Reset mid-frame: immediate return to reset values; in-flight taps discarded; no write issued.

## Configuration
- CONV_ZERO_PAD_EN defined: out-of-image taps padded as above (rd_en=0, tap_zero=1).
- Undefined: edge replication; coordinates clamped to [0,IMG_W-1]/[0,IMG_H-1], rd_en=1 for every tap, tap_zero tied 0.

## Structure
- conv_pkg: state enum, tap offset constants (dx/dy per k), filter code constants, TAPS=9.
- Sub-module conv_tap_delay: MEM_LAT-deep shift register carrying {valid, clr, tap, zero}.

## Test plan
(IMG_W=4, IMG_H=3, MEM_LAT=2)
- Reset asserted -> every output 0; release with ld=0 -> stays IDLE, busy=0.
- ld=1, filter=3'b001 -> filter_sel=001; pixel (0,0) with CONV_ZERO_PAD_EN: taps 0,1,2,3,6 rd_en=0; taps 4,5,7,8 read 0,1,4,5; acc_clr with tap 0 two cycles later.
- wr_ready tied 1 -> first wr_en at cycle 12 after accept, wr_addr 0..11 in order, complete high after 144 cycles, busy low.
- wr_ready low 5 cycles during pixel 5 WRITE -> wr_en=1, wr_addr=5 held; frame ends 5 cycles later.
- ld with filter=3'b010 while busy -> ignored, filter_sel stays 001; ld in DONE -> restarts at address 0, complete drops.
- Macro undefined, pixel (0,0) -> tap 0 reads address 0, tap 8 reads 5, tap_zero never set; rst pulsed mid-frame -> outputs 0 asynchronously, no write.
